// File: rtl/fsm_overlay_pkg.sv
// Shared constants for the programmable FSM overlay engine:
// configuration bit positions, default geometry and table sizing.
package fsm_overlay_pkg;

    localparam int CFG_RUN     = 0;
    localparam int CFG_STEP    = 1;
    localparam int CFG_RESTART = 2;
    localparam int CFG_TMO_EN  = 3;

    localparam int DEF_STATE_W     = 2;
    localparam int DEF_START_STATE = 0;

    // Number of transition-table entries: one per {state, event} pair.
    function automatic int tbl_depth(input int state_w, input int num_ev);
        int ev_w;
        ev_w = (num_ev > 1) ? $clog2(num_ev) : 1;
        return 1 << (state_w + ev_w);
    endfunction

endpackage

// File: rtl/fsm_overlay_core_arbiter.sv
// Event front end: registers the previous event levels, detects rising
// edges and selects the lowest-index edge. Other edges in the same cycle
// are dropped.
module fsm_event_arbiter
    import fsm_overlay_pkg::*;
#(
    parameter int NUM_EV = 4,
    parameter int EV_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_EV-1:0] ev_in,
    output logic              ev_hit,
    output logic [EV_W-1:0]   ev_idx
);

    logic [NUM_EV-1:0] ev_prev;
    logic [NUM_EV-1:0] ev_edge;

    // Event history, tracked every cycle regardless of run/restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_prev <= '0;
        end else begin
            ev_prev <= ev_in;
        end
    end

    assign ev_edge = ev_in & ~ev_prev;

    // Priority encoder: lowest set edge index wins.
    always_comb begin
        ev_hit = 1'b0;
        ev_idx = '0;
        for (int unsigned i = 0; i < NUM_EV; i++) begin
            if (ev_edge[i] && !ev_hit) begin
                ev_hit = 1'b1;
                ev_idx = EV_W'(i);
            end
        end
    end

endmodule

// File: rtl/fsm_overlay_core.sv
// Table-driven FSM engine fed by the CPU configuration stage.
// Optional trace history is built only when FSM_OVERLAY_TRACE_EN is defined;
// otherwise trace_out is tied to zero.
module fsm_overlay_core
    import fsm_overlay_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int NUM_EV      = 4,
    parameter int TMO_W       = 16,
    parameter int START_STATE = DEF_START_STATE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        fsm_config_in,
    input  logic                              step_req,
    input  logic                              tbl_we,
    input  logic [STATE_W+$clog2(NUM_EV)-1:0] tbl_addr,
    input  logic [STATE_W:0]                  tbl_data,
    input  logic [TMO_W-1:0]                  tmo_limit,
    input  logic [NUM_EV-1:0]                 ev_in,
    output logic [STATE_W-1:0]                state_out,
    output logic                              state_change,
    output logic                              timeout,
    output logic [4*STATE_W-1:0]              trace_out
);

    localparam int EV_W      = $clog2(NUM_EV);
    localparam int TBL_DEPTH = tbl_depth(STATE_W, NUM_EV);
    localparam logic [STATE_W-1:0] START_ST = STATE_W'(START_STATE);

    logic run, step_mode, restart, tmo_en;
    assign run       = fsm_config_in[CFG_RUN];
    assign step_mode = fsm_config_in[CFG_STEP];
    assign restart   = fsm_config_in[CFG_RESTART];
    assign tmo_en    = fsm_config_in[CFG_TMO_EN];

    logic              ev_hit;
    logic [EV_W-1:0]   ev_idx;

    fsm_event_arbiter #(
        .NUM_EV (NUM_EV),
        .EV_W   (EV_W)
    ) u_arbiter (
        .clk    (clk),
        .rst    (rst),
        .ev_in  (ev_in),
        .ev_hit (ev_hit),
        .ev_idx (ev_idx)
    );

    logic [STATE_W:0]   tbl [TBL_DEPTH];
    logic [STATE_W:0]   tbl_entry;
    logic [TMO_W-1:0]   dwell_cnt;

    logic               eval;
    logic               take;
    logic               tmo_fire;

    logic [STATE_W-1:0] state_d;
    logic [TMO_W-1:0]   cnt_d;
    logic               chg_d;
    logic               tmo_d;

    // Transition table: written by software, never reset. A lookup in the
    // write cycle sees the old entry because the array updates at the edge.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    assign tbl_entry = tbl[{state_out, ev_idx}];
    assign eval      = run & ~restart & (~step_mode | step_req);
    assign take      = eval & ev_hit & tbl_entry[STATE_W]
                     & (tbl_entry[STATE_W-1:0] != state_out);
    assign tmo_fire  = tmo_en & run & (tmo_limit != '0)
                     & (dwell_cnt == tmo_limit - TMO_W'(1));

    // Next-state selection: restart, then timeout, then event transition.
    always_comb begin
        state_d = state_out;
        cnt_d   = dwell_cnt;
        chg_d   = 1'b0;
        tmo_d   = 1'b0;
        if (restart) begin
            state_d = START_ST;
            cnt_d   = '0;
        end else if (run) begin
            if (tmo_fire) begin
                state_d = START_ST;
                cnt_d   = '0;
                tmo_d   = 1'b1;
                chg_d   = (state_out != START_ST);
            end else if (take) begin
                state_d = tbl_entry[STATE_W-1:0];
                cnt_d   = '0;
                chg_d   = 1'b1;
            end else if (!(&dwell_cnt)) begin
                cnt_d = dwell_cnt + TMO_W'(1);
            end
        end
    end

    // State register, dwell counter and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_out    <= START_ST;
            dwell_cnt    <= '0;
            state_change <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_out    <= state_d;
            dwell_cnt    <= cnt_d;
            state_change <= chg_d;
            timeout      <= tmo_d;
        end
    end

`ifdef FSM_OVERLAY_TRACE_EN
    logic [4*STATE_W-1:0] trace_q;

    // History of states entered, newest in the low bits.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            trace_q <= '0;
        end else if (chg_d) begin
            trace_q <= {trace_q[3*STATE_W-1:0], state_d};
        end
    end

    assign trace_out = trace_q;
`else
    assign trace_out = '0;
`endif

endmodule

// File: tb/tb_fsm_overlay_core.sv
// Directed self-checking bench for fsm_overlay_core.
// Trace expectations follow FSM_OVERLAY_TRACE_EN when it is defined.
module tb_fsm_overlay_core;

    localparam logic [3:0] RUN     = 4'b0001;
    localparam logic [3:0] STEP    = 4'b0010;
    localparam logic [3:0] RESTART = 4'b0100;
    localparam logic [3:0] TMO     = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fsm_config_in;
    logic        step_req;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [2:0]  tbl_data;
    logic [15:0] tmo_limit;
    logic [3:0]  ev_in;
    logic [1:0]  state_out;
    logic        state_change;
    logic        timeout;
    logic [7:0]  trace_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fsm_overlay_core #(
        .STATE_W     (2),
        .NUM_EV      (4),
        .TMO_W       (16),
        .START_STATE (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fsm_config_in (fsm_config_in),
        .step_req      (step_req),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_data      (tbl_data),
        .tmo_limit     (tmo_limit),
        .ev_in         (ev_in),
        .state_out     (state_out),
        .state_change  (state_change),
        .timeout       (timeout),
        .trace_out     (trace_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st,
                              input logic chg, input logic tmo);
        check({tag, ".state"},  32'(state_out),    32'(st));
        check({tag, ".change"}, 32'(state_change), 32'(chg));
        check({tag, ".tmo"},    32'(timeout),      32'(tmo));
`ifndef FSM_OVERLAY_TRACE_EN
        check({tag, ".trace0"}, 32'(trace_out), 32'h0);
`endif
    endtask

    task automatic wr(input logic [3:0] addr, input logic [2:0] data);
        tbl_we   = 1'b1;
        tbl_addr = addr;
        tbl_data = data;
        tick();
        tbl_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fsm_config_in = '0; step_req = 1'b0; tbl_we = 1'b0;
        tbl_addr = '0; tbl_data = '0; tmo_limit = '0; ev_in = '0;
        tick(); tick();
        rst = 1'b0;
        expect_out("reset", 2'd0, 1'b0, 1'b0);
        check("reset.trace", 32'(trace_out), 32'h0);

        // table programming, run=0; address = {state, event}, data = {valid, next}
        wr(4'd0,  3'b000);  // {0,0} invalid
        wr(4'd1,  3'b110);  // {0,1} -> 2
        wr(4'd2,  3'b000);  // {0,2} invalid (rewritten in collision test)
        wr(4'd3,  3'b101);  // {0,3} -> 1
        wr(4'd7,  3'b110);  // {1,3} -> 2
        wr(4'd9,  3'b111);  // {2,1} -> 3
        wr(4'd11, 3'b111);  // {2,3} -> 3
        wr(4'd15, 3'b101);  // {3,3} -> 1
        expect_out("prog_idle", 2'd0, 1'b0, 1'b0);

        // priority: ev0 wins with invalid entry, ev1 dropped
        fsm_config_in = RUN;
        ev_in = 4'b0011; tick();
        expect_out("prio_inv", 2'd0, 1'b0, 1'b0);
        ev_in = 4'b0000; tick();
        expect_out("prio_idle", 2'd0, 1'b0, 1'b0);
        ev_in = 4'b0010; tick();
        expect_out("ev1_go", 2'd2, 1'b1, 1'b0);
        ev_in = 4'b0000; tick();
        expect_out("ev1_after", 2'd2, 1'b0, 1'b0);

        // step mode
        fsm_config_in = RUN | STEP;
        ev_in = 4'b0010; step_req = 1'b0; tick();
        expect_out("step_no_req", 2'd2, 1'b0, 1'b0);
        ev_in = 4'b0000; tick();
        ev_in = 4'b0010; step_req = 1'b1; tick();
        expect_out("step_req", 2'd3, 1'b1, 1'b0);
        ev_in = 4'b0000; step_req = 1'b0; tick();
        expect_out("step_after", 2'd3, 1'b0, 1'b0);

        // restart from state 3; ev3 would otherwise go to 1
        fsm_config_in = RUN | RESTART;
        ev_in = 4'b1000; tick();
        expect_out("restart_hold", 2'd0, 1'b0, 1'b0);
        ev_in = 4'b0000; tick();
        ev_in = 4'b1000; tick();
        expect_out("restart_ev_lost", 2'd0, 1'b0, 1'b0);
        ev_in = 4'b0000;
        fsm_config_in = RUN; tick();
        expect_out("restart_release", 2'd0, 1'b0, 1'b0);

        // timeout after 5 cycles dwelling in state 2
        tmo_limit = 16'd5;
        fsm_config_in = RUN | TMO;
        ev_in = 4'b0010; tick();
        expect_out("tmo_enter2", 2'd2, 1'b1, 1'b0);
        ev_in = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_out($sformatf("tmo_wait%0d", k), 2'd2, 1'b0, 1'b0);
        end
        tick();
        expect_out("tmo_fire", 2'd0, 1'b1, 1'b1);
        tick();
        expect_out("tmo_clear", 2'd0, 1'b0, 1'b0);
        // dwelling in START_STATE: timeout pulses without a state change
        for (int k = 7; k <= 9; k++) begin
            tick();
        end
        expect_out("tmo_start_wait", 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("tmo_start_fire", 2'd0, 1'b0, 1'b1);

        // event edge landing on the timeout cycle: timeout wins
        ev_in = 4'b0010; tick();
        expect_out("tmo2_enter2", 2'd2, 1'b1, 1'b0);
        ev_in = 4'b0000;
        for (int k = 1; k <= 4; k++) tick();
        expect_out("tmo2_wait", 2'd2, 1'b0, 1'b0);
        ev_in = 4'b1000; tick();
        expect_out("tmo2_beats_ev", 2'd0, 1'b1, 1'b1);
        ev_in = 4'b0000; tick();
        expect_out("tmo2_after", 2'd0, 1'b0, 1'b0);
        fsm_config_in = RUN;
        tmo_limit = 16'd0;

        // write/read collision on {0,2}
        tbl_we = 1'b1; tbl_addr = 4'd2; tbl_data = 3'b111; ev_in = 4'b0100;
        tick();
        tbl_we = 1'b0;
        expect_out("coll_old", 2'd0, 1'b0, 1'b0);
        ev_in = 4'b0000; tick();
        ev_in = 4'b0100; tick();
        expect_out("coll_new", 2'd3, 1'b1, 1'b0);
        ev_in = 4'b0000; tick();

        // reset during the state_change pulse
        ev_in = 4'b1000; tick();
        expect_out("pre_rst", 2'd1, 1'b1, 1'b0);
        ev_in = 4'b0000; rst = 1'b1; tick();
        rst = 1'b0;
        expect_out("mid_rst", 2'd0, 1'b0, 1'b0);
        check("mid_rst.trace", 32'(trace_out), 32'h0);

        // sequence 0->1->2->3->1 via ev3
        ev_in = 4'b1000; tick(); ev_in = 4'b0000;
        expect_out("seq1", 2'd1, 1'b1, 1'b0);
`ifdef FSM_OVERLAY_TRACE_EN
        check("trace1", 32'(trace_out), 32'h01);
`endif
        tick();
        ev_in = 4'b1000; tick(); ev_in = 4'b0000;
        expect_out("seq2", 2'd2, 1'b1, 1'b0);
        tick();
        ev_in = 4'b1000; tick(); ev_in = 4'b0000;
        expect_out("seq3", 2'd3, 1'b1, 1'b0);
        tick();
        ev_in = 4'b1000; tick(); ev_in = 4'b0000;
        expect_out("seq4", 2'd1, 1'b1, 1'b0);
`ifdef FSM_OVERLAY_TRACE_EN
        check("trace_seq", 32'(trace_out), 32'(8'b01_10_11_01));
`else
        check("trace_seq_off", 32'(trace_out), 32'h0);
`endif
        tick();

        // run=0 freezes; held event does not re-fire on resume
        fsm_config_in = 4'b0000;
        ev_in = 4'b1000; tick();
        expect_out("frozen", 2'd1, 1'b0, 1'b0);
        fsm_config_in = RUN; tick();
        expect_out("resume_no_refire", 2'd1, 1'b0, 1'b0);
        ev_in = 4'b0000; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
